jamma_joy_mux: RTL and testbench
================================

JAMMA_JOY_MUX -- requirements
Module: jamma_joy_mux

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8, meaning cycles JSELECT is held before each sample (legal range 3..255).
REQ-002 SHALL have parameter DEB_COUNT, default 3, meaning consecutive identical samples required before an output changes (legal range 1..15).
REQ-003 SHALL have port CLK  input  1  pixel-rate clock, all logic rising-edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous active-low reset.
REQ-005 SHALL have port JJOY  input  8  shared JAMMA joystick/start bus, active-low, asynchronous.
REQ-006 SHALL have port JOYSTICK  input  6  local DB9 joystick, active-low, asynchronous.
REQ-007 SHALL have port JCOIN  input  2  coin switches, active-low, asynchronous.
REQ-008 SHALL have port JSELECT  output  1  splitter select: 0 selects player 1, 1 selects player 2.
REQ-009 SHALL have port O_JOY1  output  8  debounced player-1 bus, active-low.
REQ-010 SHALL have port O_JOY2  output  8  debounced player-2 bus, active-low.
REQ-011 SHALL have port O_COIN  output  2  debounced coins, active-low.
REQ-012 SHALL have port O_VALID  output  1  one-cycle strobe per completed P1+P2 scan.

Function
REQ-013 JJOY, JOYSTICK and JCOIN SHALL each pass a 2-flop synchronizer before any other use.
REQ-014 FSM states SHALL be P1_SETTLE, P1_SAMPLE, P2_SETTLE, P2_SAMPLE, in that fixed cyclic order.
REQ-015 In each SETTLE state a settle counter SHALL increment from 0 each cycle; at SETTLE_CYCLES-1 the FSM SHALL move to the matching SAMPLE state next cycle.
REQ-016 Each SAMPLE state SHALL last exactly one cycle, capture the synchronized JJOY into that player's sample register, clear the settle counter, and advance.
REQ-017 JSELECT SHALL be registered: 0 during P1_SETTLE and P1_SAMPLE, 1 during P2_SETTLE and P2_SAMPLE; full scan period = 2*(SETTLE_CYCLES+1) cycles.
REQ-018 Per player, at each capture: if new sample equals previous sample, stable counter SHALL increment, saturating at DEB_COUNT; otherwise it SHALL clear to 0.
REQ-019 When a stable counter equals DEB_COUNT after an update, the player output SHALL load the sample on the following cycle; it SHALL otherwise hold.
REQ-020 A one-sample glitch SHALL never reach O_JOY1/O_JOY2 when DEB_COUNT >= 1.
REQ-021 O_VALID SHALL pulse high exactly one cycle, the cycle after each P2_SAMPLE.
REQ-022 Coins SHALL be sampled on O_VALID cycles and debounced with the same DEB_COUNT rule as REQ-018/019, using a separate counter.
REQ-023 Counter widths SHALL be 8 bits (settle) and 4 bits (stable); no counter SHALL wrap.

Reset
REQ-024 On RESET_N low, asynchronously: FSM = P1_SETTLE, all counters 0, JSELECT 0, O_JOY1 8'hFF, O_JOY2 8'hFF, O_COIN 2'b11, O_VALID 0, sample registers and synchronizers all-ones.
REQ-025 Reset asserted mid-scan SHALL abandon the scan without an O_VALID pulse; after release, first P1_SAMPLE SHALL occur SETTLE_CYCLES cycles later.

Configuration
REQ-026 With macro JAMMA_DB9_MERGE_EN defined, O_JOY1 source SHALL be the P1 sample bitwise ANDed with {2'b11, synchronized JOYSTICK} before debounce.
REQ-027 Without JAMMA_DB9_MERGE_EN, JOYSTICK SHALL be ignored and O_JOY1 SHALL derive from JJOY only.

Verification (defaults: SETTLE_CYCLES=8, DEB_COUNT=3)
REQ-028 Release reset, idle inputs 8'hFF -> JSELECT toggles every 9 cycles, O_VALID every 18 cycles, outputs stay 8'hFF.
REQ-029 JJOY=8'hFE only while JSELECT=0, held steady -> O_JOY1 becomes 8'hFE after the 4th P1 capture, O_JOY2 stays 8'hFF.
REQ-030 JJOY bit0 low for one P2 capture only -> O_JOY2 remains 8'hFF.
REQ-031 JCOIN=2'b10 held 100 cycles -> O_COIN=2'b10 after 4th O_VALID; release -> 2'b11 after 4 further O_VALID.
REQ-032 RESET_N pulsed low during P2_SETTLE -> all outputs return to reset values immediately, no O_VALID in that scan.
REQ-033 With JAMMA_DB9_MERGE_EN, JJOY=8'hFF, JOYSTICK=6'b111101 -> O_JOY1=8'hFD; without macro -> O_JOY1=8'hFF.

Source files
------------

// File: rtl/jamma_joy_mux.sv
// JAMMA player-1/player-2 joystick demultiplexer with per-player and coin debouncing.
// Optional build macro JAMMA_DB9_MERGE_EN folds the local DB9 joystick into player 1.

module jamma_joy_deb #(
  parameter int W         = 8,
  parameter int DEB_COUNT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         capture,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam logic [3:0] DEB_MAX = 4'(DEB_COUNT);

  logic [W-1:0] samp;
  logic [3:0]   stab_cnt;
  logic         upd;

  // Output follows one cycle after the capture that reaches a full stable run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp     <= '1;
      stab_cnt <= 4'd0;
      upd      <= 1'b0;
      dout     <= '1;
    end else begin
      upd <= capture;
      if (capture) begin
        samp <= din;
        if (din == samp) begin
          if (stab_cnt != DEB_MAX) stab_cnt <= stab_cnt + 4'd1;
        end else begin
          stab_cnt <= 4'd0;
        end
      end
      if (upd && (stab_cnt == DEB_MAX)) dout <= samp;
    end
  end

endmodule

// state     | meaning
// P1_SETTLE | JSELECT=0, waiting for the splitter to settle on player 1
// P1_SAMPLE | capture player-1 bus
// P2_SETTLE | JSELECT=1, waiting for the splitter to settle on player 2
// P2_SAMPLE | capture player-2 bus; O_VALID follows next cycle
module jamma_joy_mux #(
  parameter int SETTLE_CYCLES = 8,
  parameter int DEB_COUNT     = 3
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] JJOY,
  input  logic [5:0] JOYSTICK,
  input  logic [1:0] JCOIN,
  output logic       JSELECT,
  output logic [7:0] O_JOY1,
  output logic [7:0] O_JOY2,
  output logic [1:0] O_COIN,
  output logic       O_VALID
);

  localparam logic [1:0] P1_SETTLE = 2'd0;
  localparam logic [1:0] P1_SAMPLE = 2'd1;
  localparam logic [1:0] P2_SETTLE = 2'd2;
  localparam logic [1:0] P2_SAMPLE = 2'd3;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  logic [7:0] jjoy_m, jjoy_s;
  logic [5:0] joy_m, joy_s;
  logic [1:0] coin_m, coin_s;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      jjoy_m <= '1;
      jjoy_s <= '1;
      joy_m  <= '1;
      joy_s  <= '1;
      coin_m <= '1;
      coin_s <= '1;
    end else begin
      jjoy_m <= JJOY;
      jjoy_s <= jjoy_m;
      joy_m  <= JOYSTICK;
      joy_s  <= joy_m;
      coin_m <= JCOIN;
      coin_s <= coin_m;
    end
  end

  logic [1:0] state, next_state;
  logic [7:0] settle_cnt;

  always_comb begin
    next_state = state;
    case (state)
      P1_SETTLE: if (settle_cnt == SETTLE_LAST) next_state = P1_SAMPLE;
      P1_SAMPLE: next_state = P2_SETTLE;
      P2_SETTLE: if (settle_cnt == SETTLE_LAST) next_state = P2_SAMPLE;
      P2_SAMPLE: next_state = P1_SETTLE;
      default:   next_state = P1_SETTLE;
    endcase
  end

  // JSELECT is derived from the next state so it is registered yet aligned with state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= P1_SETTLE;
      settle_cnt <= 8'd0;
      JSELECT    <= 1'b0;
      O_VALID    <= 1'b0;
    end else begin
      state   <= next_state;
      JSELECT <= next_state[1];
      O_VALID <= (state == P2_SAMPLE);
      if ((state == P1_SAMPLE) || (state == P2_SAMPLE)) begin
        settle_cnt <= 8'd0;
      end else if (settle_cnt != 8'hFF) begin
        settle_cnt <= settle_cnt + 8'd1;
      end
    end
  end

  logic [7:0] p1_src;

`ifdef JAMMA_DB9_MERGE_EN
  assign p1_src = jjoy_s & {2'b11, joy_s};
`else
  logic unused_joy;
  assign unused_joy = &{1'b0, joy_s};
  assign p1_src     = jjoy_s;
`endif

  jamma_joy_deb #(.W(8), .DEB_COUNT(DEB_COUNT)) u_deb_p1 (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .capture (state == P1_SAMPLE),
    .din     (p1_src),
    .dout    (O_JOY1)
  );

  jamma_joy_deb #(.W(8), .DEB_COUNT(DEB_COUNT)) u_deb_p2 (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .capture (state == P2_SAMPLE),
    .din     (jjoy_s),
    .dout    (O_JOY2)
  );

  // Coins are sampled once per full scan, on the O_VALID cycle.
  jamma_joy_deb #(.W(2), .DEB_COUNT(DEB_COUNT)) u_deb_coin (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .capture (O_VALID),
    .din     (coin_s),
    .dout    (O_COIN)
  );

endmodule

// File: tb/tb_jamma_joy_mux.sv
// Self-checking bench for jamma_joy_mux: vector table, directed corner sequences and a
// randomized run, all compared every cycle against a scan-position / sample-window model.
module tb_jamma_joy_mux;

  localparam int S = 8;
  localparam int D = 3;
  localparam int P = 2 * (S + 1);
`ifdef JAMMA_DB9_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [7:0] JJOY = 8'hFF;
  logic [5:0] JOYSTICK = 6'h3F;
  logic [1:0] JCOIN = 2'b11;
  logic       JSELECT;
  logic [7:0] O_JOY1, O_JOY2;
  logic [1:0] O_COIN;
  logic       O_VALID;

  jamma_joy_mux #(.SETTLE_CYCLES(S), .DEB_COUNT(D)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .JJOY     (JJOY),
    .JOYSTICK (JOYSTICK),
    .JCOIN    (JCOIN),
    .JSELECT  (JSELECT),
    .O_JOY1   (O_JOY1),
    .O_JOY2   (O_JOY2),
    .O_COIN   (O_COIN),
    .O_VALID  (O_VALID)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in scan from edge count, synchronizer as a two-edge delay
  // into an input history, debounce as "last D+1 captured samples all equal".
  typedef logic [7:0] q8_t[$];
  int         t;
  q8_t        hj, hk, hc, q1, q2, qc;
  bit         pv1, pv2, pvc;
  logic [7:0] pd1, pd2, pdc;
  logic [7:0] m_joy1, m_joy2;
  logic [1:0] m_coin;
  logic       m_valid, m_jsel;

  function automatic bit window_stable(q8_t q);
    int n = q.size();
    if (n < D + 1) return 1'b0;
    for (int i = 1; i <= D; i++)
      if (q[n-1-i] != q[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    t = 0;
    hj.delete(); hk.delete(); hc.delete();
    q1.delete(); q2.delete(); qc.delete();
    q1.push_back(8'hFF); q2.push_back(8'hFF); qc.push_back(8'h03);
    pv1 = 0; pv2 = 0; pvc = 0;
    m_joy1 = 8'hFF; m_joy2 = 8'hFF; m_coin = 2'b11; m_valid = 0; m_jsel = 0;
  endtask

  task automatic model_edge();
    int c, p;
    logic [7:0] sj, v;
    logic [5:0] sk;
    logic [1:0] sc;
    if (!RESET_N) begin
      model_reset();
      return;
    end
    if (pv1) m_joy1 = pd1;
    if (pv2) m_joy2 = pd2;
    if (pvc) m_coin = pdc[1:0];
    pv1 = 0; pv2 = 0; pvc = 0;
    c = t;
    t++;
    hj.push_back(JJOY);
    hk.push_back({2'b00, JOYSTICK});
    hc.push_back({6'b0, JCOIN});
    sj = (c >= 2) ? hj[c-2] : 8'hFF;
    sk = (c >= 2) ? hk[c-2][5:0] : 6'h3F;
    sc = (c >= 2) ? hc[c-2][1:0] : 2'b11;
    p = c % P;
    if (p == S) begin
      v = MERGE ? (sj & {2'b11, sk}) : sj;
      q1.push_back(v);
      if (window_stable(q1)) begin pv1 = 1; pd1 = v; end
    end
    if (p == 2 * S + 1) begin
      q2.push_back(sj);
      if (window_stable(q2)) begin pv2 = 1; pd2 = sj; end
    end
    if (m_valid) begin
      qc.push_back({6'b0, sc});
      if (window_stable(qc)) begin pvc = 1; pdc = {6'b0, sc}; end
    end
    m_valid = (p == 2 * S + 1);
    m_jsel  = (t % P) > S;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    chk("cycle", {12'b0, JSELECT, O_VALID, O_JOY1, O_JOY2, O_COIN},
        {12'b0, m_jsel, m_valid, m_joy1, m_joy2, m_coin});
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    #1;
    chk("rst_async", {12'b0, JSELECT, O_VALID, O_JOY1, O_JOY2, O_COIN},
        {12'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 2'b11});
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic wait_valids(input int n, output int ticks);
    int seen = 0;
    ticks = 0;
    while (seen < n && ticks < 20 * P) begin
      tick();
      ticks++;
      if (O_VALID) seen++;
    end
    if (seen < n) chk("valid_timeout", seen, n);
  endtask

  typedef struct {
    logic [7:0] jjoy;
    logic [1:0] jcoin;
    logic [5:0] joy;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [1:0] ec;
  } vec_t;

  vec_t vt[6];

  initial begin
    int nv, nj, used;
    logic prev_j;
    int hold_j, hold_k, hold_c;

    vt[0] = '{8'hFF, 2'b11, 6'h3F, 8'hFF, 8'hFF, 2'b11};
    vt[1] = '{8'hFE, 2'b11, 6'h3F, 8'hFE, 8'hFE, 2'b11};
    vt[2] = '{8'hA5, 2'b10, 6'h3F, 8'hA5, 8'hA5, 2'b10};
    vt[3] = '{8'h00, 2'b00, 6'h3F, 8'h00, 8'h00, 2'b00};
    vt[4] = '{8'hFF, 2'b11, 6'h3D, MERGE ? 8'hFD : 8'hFF, 8'hFF, 2'b11};
    vt[5] = '{8'h7F, 2'b01, 6'h2A, MERGE ? 8'h6A : 8'h7F, 8'h7F, 2'b01};

    model_reset();
    @(negedge CLK);
    do_reset();

    // Vector table: constant inputs from reset, outputs settled after 100 cycles.
    for (int i = 0; i < 6; i++) begin
      JJOY = vt[i].jjoy; JCOIN = vt[i].jcoin; JOYSTICK = vt[i].joy;
      do_reset();
      for (int k = 0; k < 100; k++) tick();
      chk($sformatf("vec%0d_joy1", i), O_JOY1, vt[i].e1);
      chk($sformatf("vec%0d_joy2", i), O_JOY2, vt[i].e2);
      chk($sformatf("vec%0d_coin", i), O_COIN, vt[i].ec);
    end

    // Idle scan timing.
    JJOY = 8'hFF; JCOIN = 2'b11; JOYSTICK = 6'h3F;
    do_reset();
    nv = 0; nj = 0; prev_j = JSELECT;
    for (int k = 1; k <= 180; k++) begin
      tick();
      if (O_VALID) nv++;
      if (JSELECT != prev_j) nj++;
      prev_j = JSELECT;
      if (k == 8) chk("jsel_before_p1_sample", JSELECT, 1'b0);
      if (k == 9) chk("jsel_after_p1_sample", JSELECT, 1'b1);
    end
    chk("idle_valid_count", nv, 10);
    chk("idle_jsel_toggles", nj, 20);
    chk("idle_outputs", {O_JOY1, O_JOY2, 6'b0, O_COIN}, {8'hFF, 8'hFF, 8'h03});

    // Player-1-only press: appears after the 4th P1 capture.
    do_reset();
    for (int k = 1; k <= 100; k++) begin
      JJOY = JSELECT ? 8'hFF : 8'hFE;
      tick();
      if (k == 63) chk("p1_before_4th", O_JOY1, 8'hFF);
      if (k == 64) chk("p1_after_4th", O_JOY1, 8'hFE);
    end
    chk("p1_only_joy2", O_JOY2, 8'hFF);

    // One-capture glitch on player 2.
    JJOY = 8'hFF;
    do_reset();
    for (int k = 1; k <= 150; k++) begin
      JJOY = (k >= 28 && k <= 42) ? 8'hFE : 8'hFF;
      tick();
    end
    chk("glitch_joy2", O_JOY2, 8'hFF);
    chk("glitch_joy1", O_JOY1, 8'hFF);

    // Coin press and release.
    JJOY = 8'hFF; JCOIN = 2'b10;
    do_reset();
    wait_valids(4, used);
    chk("coin_pre_capture", O_COIN, 2'b11);
    tick(); used++;
    chk("coin_captured", O_COIN, 2'b11);
    tick(); used++;
    chk("coin_pressed", O_COIN, 2'b10);
    while (used < 100) begin tick(); used++; end
    JCOIN = 2'b11;
    wait_valids(4, used);
    tick();
    chk("coin_release_pending", O_COIN, 2'b10);
    tick();
    chk("coin_released", O_COIN, 2'b11);

    // Reset in the middle of P2_SETTLE.
    JJOY = 8'h00; JCOIN = 2'b00;
    do_reset();
    for (int k = 0; k < 100; k++) tick();
    nv = 0;
    while (!JSELECT && nv < 2 * P) begin tick(); nv++; end
    chk("reach_p2", JSELECT, 1'b1);
    tick(); tick(); tick();
    chk("pre_rst_outputs", {O_JOY1, O_JOY2, 6'b0, O_COIN}, 24'h0);
    JJOY = 8'hFF; JCOIN = 2'b11;
    do_reset();
    nv = 0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (O_VALID) nv++;
    end
    chk("no_valid_after_rst", nv, 0);
    tick();
    chk("first_valid_after_rst", O_VALID, 1'b1);

    // Randomized run.
    do_reset();
    hold_j = 0; hold_k = 0; hold_c = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold_j == 0) begin
        JJOY = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        hold_j = $urandom_range(1, 160);
      end
      if (hold_k == 0) begin
        JOYSTICK = 6'($urandom);
        hold_k = $urandom_range(1, 200);
      end
      if (hold_c == 0) begin
        JCOIN = 2'($urandom);
        hold_c = $urandom_range(1, 300);
      end
      hold_j--; hold_k--; hold_c--;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
